// File: rtl/glitch_sequencer.sv
// Glitch injection sequencer: after arming, waits for a trigger rising edge,
// then emits a programmed train of glitch_en pulses into the glitch clock mux.
module glitch_sequencer #(
  parameter int DLY_W = 16,
  parameter int WID_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig_in,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [WID_W-1:0] cfg_width,
  input  logic [WID_W-1:0] cfg_gap,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             glitch_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] glitch_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_PULSE, S_GAP, S_DONE
  } state_t;

  state_t           state;
  logic             trig_prev;
  logic [DLY_W-1:0] dly_sh, dcnt;
  logic [WID_W-1:0] wid_sh, gap_sh, wcnt;
  logic [CNT_W-1:0] cnt_sh;

  logic             trig_edge;
  logic [WID_W-1:0] wid_n, gap_n;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W:0]   pulses_done;
  logic             last_pulse;

  // Zero-valued settings behave as 1 so every sequence makes progress.
  assign trig_edge   = trig_in & ~trig_prev;
  assign wid_n       = (wid_sh == '0) ? WID_W'(1) : wid_sh;
  assign gap_n       = (gap_sh == '0) ? WID_W'(1) : gap_sh;
  assign cnt_n       = (cnt_sh == '0) ? CNT_W'(1) : cnt_sh;
  assign pulses_done = {1'b0, glitch_idx} + (CNT_W+1)'(1);
  assign last_pulse  = pulses_done >= {1'b0, cnt_n};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      trig_prev  <= 1'b0;
      glitch_en  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      glitch_idx <= '0;
      dly_sh     <= '0;
      wid_sh     <= '0;
      gap_sh     <= '0;
      cnt_sh     <= '0;
      dcnt       <= '0;
      wcnt       <= '0;
    end else begin
      trig_prev <= trig_in;
      if (abort) begin
        state     <= S_IDLE;
        glitch_en <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            done <= 1'b0;
            if (arm) begin
              state      <= S_ARMED;
              busy       <= 1'b1;
              glitch_idx <= '0;
              dly_sh     <= cfg_delay;
              wid_sh     <= cfg_width;
              gap_sh     <= cfg_gap;
              cnt_sh     <= cfg_count;
            end
          end
          S_ARMED: begin
            if (trig_edge) begin
              if (dly_sh == '0) begin
                state     <= S_PULSE;
                glitch_en <= 1'b1;
                wcnt      <= wid_n;
              end else begin
                state <= S_DELAY;
                dcnt  <= dly_sh;
              end
            end
          end
          S_DELAY: begin
            if (dcnt <= DLY_W'(1)) begin
              state     <= S_PULSE;
              glitch_en <= 1'b1;
              wcnt      <= wid_n;
            end else begin
              dcnt <= dcnt - DLY_W'(1);
            end
          end
          S_PULSE: begin
            if (wcnt <= WID_W'(1)) begin
              glitch_en <= 1'b0;
              if (last_pulse) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= S_GAP;
                wcnt  <= gap_n;
              end
            end else begin
              wcnt <= wcnt - WID_W'(1);
            end
          end
          S_GAP: begin
            if (wcnt <= WID_W'(1)) begin
              state      <= S_PULSE;
              glitch_en  <= 1'b1;
              wcnt       <= wid_n;
              glitch_idx <= glitch_idx + CNT_W'(1);
            end else begin
              wcnt <= wcnt - WID_W'(1);
            end
          end
          S_DONE: begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench for glitch_sequencer: directed runs push per-cycle expected
// outputs keyed by cycle; a negedge monitor pops and compares them.
module tb_glitch_sequencer;
  localparam int DLY_W = 16;
  localparam int WID_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             arm = 1'b0;
  logic             abort = 1'b0;
  logic             trig_in = 1'b0;
  logic [DLY_W-1:0] cfg_delay = '0;
  logic [WID_W-1:0] cfg_width = '0;
  logic [WID_W-1:0] cfg_gap = '0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic             glitch_en, busy, done;
  logic [CNT_W-1:0] glitch_idx;

  // v = {glitch_en, busy, done, glitch_idx}
  typedef struct {
    int               key;
    logic [CNT_W+2:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   a, t;

  glitch_sequencer #(.DLY_W(DLY_W), .WID_W(WID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig_in(trig_in),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap),
    .cfg_count(cfg_count), .glitch_en(glitch_en), .busy(busy), .done(done),
    .glitch_idx(glitch_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key k holds the outputs registered at posedge k-1, visible before posedge k.
  always @(negedge clk) begin : mon
    exp_t             e;
    logic [CNT_W+2:0] got;
    got = {glitch_en, busy, done, glitch_idx};
    while (sb.size() > 0 && sb[0].key <= cyc + 1) begin
      e = sb.pop_front();
      checks++;
      if (e.key != cyc + 1 || got !== e.v) begin
        errors++;
        $display("FAIL outputs key=%0d at=%0d got en/busy/done/idx=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                 e.key, cyc + 1, got[CNT_W+2], got[CNT_W+1], got[CNT_W], got[CNT_W-1:0],
                 e.v[CNT_W+2], e.v[CNT_W+1], e.v[CNT_W], e.v[CNT_W-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d pending=%0d required=0", cyc, sb.size());
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic expr(input int k0, input int k1, input logic en, input logic b,
                      input logic d, input int idx);
    logic [CNT_W-1:0] iv;
    iv = idx[CNT_W-1:0];
    for (int k = k0; k <= k1; k++) sb.push_back('{key: k, v: {en, b, d, iv}});
  endtask

  task automatic do_arm(input int d, input int w, input int g, input int c);
    cfg_delay = DLY_W'(d);
    cfg_width = WID_W'(w);
    cfg_gap   = WID_W'(g);
    cfg_count = CNT_W'(c);
    arm = 1'b1;
    step();
    arm = 1'b0;
    a = cyc;
    expr(a + 1, a + 1, 0, 1, 0, 0);
  endtask

  initial begin
    // reset state
    step(); step();
    expr(cyc + 1, cyc + 1, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(); step();

    // single pulse: delay 5, width 2
    do_arm(5, 2, 1, 1);
    step();
    trig_in = 1'b1; t = cyc + 1;
    expr(t + 1, t + 5, 0, 1, 0, 0);
    expr(t + 6, t + 7, 1, 1, 0, 0);
    expr(t + 8, t + 8, 0, 0, 1, 0);
    expr(t + 9, t + 10, 0, 0, 0, 0);
    run_to(t + 10);
    trig_in = 1'b0; step();

    // pulse train with a second edge landing in PULSE
    do_arm(0, 1, 2, 3);
    step();
    trig_in = 1'b1; t = cyc + 1;
    expr(t + 1, t + 1, 1, 1, 0, 0);
    expr(t + 2, t + 3, 0, 1, 0, 0);
    expr(t + 4, t + 4, 1, 1, 0, 1);
    expr(t + 5, t + 6, 0, 1, 0, 1);
    expr(t + 7, t + 7, 1, 1, 0, 2);
    expr(t + 8, t + 8, 0, 0, 1, 2);
    expr(t + 9, t + 12, 0, 0, 0, 2);
    run_to(t);
    trig_in = 1'b0;
    run_to(t + 3);
    trig_in = 1'b1;
    run_to(t + 12);
    trig_in = 1'b0; step();

    // all-zero config behaves as single one-cycle pulse
    do_arm(0, 0, 0, 0);
    step();
    trig_in = 1'b1; t = cyc + 1;
    expr(t + 1, t + 1, 1, 1, 0, 0);
    expr(t + 2, t + 2, 0, 0, 1, 0);
    expr(t + 3, t + 4, 0, 0, 0, 0);
    run_to(t + 4);

    // trigger already high at arm must not fire
    do_arm(2, 1, 1, 1);
    expr(a + 2, a + 6, 0, 1, 0, 0);
    run_to(a + 5);
    trig_in = 1'b0; step();
    trig_in = 1'b1; t = cyc + 1;
    expr(t + 1, t + 2, 0, 1, 0, 0);
    expr(t + 3, t + 3, 1, 1, 0, 0);
    expr(t + 4, t + 4, 0, 0, 1, 0);
    expr(t + 5, t + 5, 0, 0, 0, 0);
    run_to(t + 5);
    trig_in = 1'b0; step();

    // arm while busy and cfg changes mid-run are ignored
    do_arm(4, 3, 1, 1);
    step();
    trig_in = 1'b1; t = cyc + 1;
    expr(t + 1, t + 4, 0, 1, 0, 0);
    expr(t + 5, t + 7, 1, 1, 0, 0);
    expr(t + 8, t + 8, 0, 0, 1, 0);
    expr(t + 9, t + 10, 0, 0, 0, 0);
    run_to(t + 1);
    arm = 1'b1; cfg_delay = 1; cfg_width = 1; cfg_count = 5; cfg_gap = 9;
    step();
    arm = 1'b0;
    run_to(t + 10);
    trig_in = 1'b0; step();

    // abort during DELAY
    do_arm(10, 1, 1, 1);
    step();
    trig_in = 1'b1; t = cyc + 1;
    expr(t + 1, t + 3, 0, 1, 0, 0);
    expr(t + 4, t + 20, 0, 0, 0, 0);
    run_to(t + 2);
    abort = 1'b1; step();
    abort = 1'b0;
    run_to(t + 20);
    trig_in = 1'b0; step();

    // abort together with arm in IDLE stays idle
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    a = cyc;
    expr(a + 1, a + 3, 0, 0, 0, 0);
    run_to(a + 3);

    // reset during the second cycle of a pulse
    do_arm(3, 4, 1, 1);
    step();
    trig_in = 1'b1; t = cyc + 1;
    expr(t + 1, t + 3, 0, 1, 0, 0);
    expr(t + 4, t + 5, 1, 1, 0, 0);
    expr(t + 6, t + 8, 0, 0, 0, 0);
    run_to(t + 4);
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    run_to(t + 8);
    step(); step();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
